// File: rtl/counter_pkg.sv
// Shared definitions for the counter family (up-counters and the countdown timer).
//   cd_state_t    : countdown timer control states IDLE / RUN / DONE
//   CNT_W_DEFAULT : default counter width in bits
package counter_pkg;

    localparam int unsigned CNT_W_DEFAULT = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cd_state_t;

endpackage

// File: rtl/down_counter_core.sv
// WIDTH-bit down-counter register with synchronous clear, load and decrement,
// plus a combinational zero detect.
//   clk      in  rising-edge clock
//   rst      in  synchronous active-high reset, clears the count
//   clr      in  synchronous clear (highest priority after rst)
//   load     in  load load_val into the count
//   dec      in  decrement by one; saturates at zero
//   load_val in  value for load
//   count    out registered count
//   bo       out borrow-out, high when count == 0
module down_counter_core
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             bo
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            // Guard keeps the count from wrapping below zero.
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign bo    = (count_q == '0);

endmodule

// File: rtl/countdown_timer.sv
// Loadable countdown timer with start/done/ack handshake.
// Loaded value N reaches zero after N enabled cycles; done then holds until ack.
//   clk      in  rising-edge clock
//   rst      in  synchronous active-high reset
//   clean    in  synchronous clear, same effect as rst, lower priority
//   start    in  load request, honoured only in IDLE
//   load_val in  initial count sampled with start
//   en       in  decrement enable, honoured only in RUN
//   ack      in  acknowledge of done, honoured only in DONE
//   busy     out high in RUN
//   done     out high in DONE
//   bo       out combinational count == 0
//   count    out current count
module countdown_timer
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clean,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             ack,
    output logic             busy,
    output logic             done,
    output logic             bo,
    output logic [WIDTH-1:0] count
);

    cd_state_t state_q;
    cd_state_t state_d;

    logic cnt_clr;
    logic cnt_load;
    logic cnt_dec;

    always_comb begin
        state_d  = state_q;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;

        if (clean) begin
            state_d = IDLE;
            cnt_clr = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (load_val != '0) begin
                            cnt_load = 1'b1;
                            state_d  = RUN;
                        end else begin
                            // Zero load skips RUN entirely.
                            cnt_clr = 1'b1;
                            state_d = DONE;
                        end
                    end
                end
                RUN: begin
                    if (en) begin
                        cnt_dec = 1'b1;
                        if (count <= WIDTH'(1)) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (ack) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_clr = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    down_counter_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (load_val),
        .count    (count),
        .bo       (bo)
    );

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counter with a start/done/ack handshake: the decrementing counterpart of the team's 3-bit up-counter (`counter3`). A controller loads a terminal count and starts the block. The block then decrements once per enabled cycle and raises a level `done` at zero, which stays up until the controller acknowledges it. It sits in the datapath controller as the iteration/delay timer next to the up-counters.

## Interface
- `WIDTH`, default 3: counter width in bits; must be ≥ 1.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  synchronous, active-high reset; sampled on the `clk` rising edge.
- `clean`  in  1  synchronous clear; same effect as `rst`, lower priority than `rst`.
- `start`  in  1  load request; honoured only in IDLE.
- `load_val`  in  WIDTH  initial count, sampled with `start`.
- `en`  in  1  decrement enable; honoured only in RUN.
- `ack`  in  1  acknowledges `done`; honoured only in DONE.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `bo`  out  1  borrow-out, combinational `count == 0`.
- `count`  out  WIDTH  current counter value.

## Operation
- FSM states: IDLE, RUN, DONE. The state register and the count register are the only storage.
- Reset/clear priority: `rst` > `clean` > everything else.
  - Either one forces state IDLE and `count` = 0 on the next edge, whatever the current state.
  - Reset values: `busy` = 0, `done` = 0, `count` = 0, `bo` = 1.
- IDLE:
  - `count` holds its value.
  - `start` = 1 with `load_val` ≠ 0: `count` ← `load_val`, go to RUN.
  - `start` = 1 with `load_val` = 0: `count` ← 0, go directly to DONE (no RUN cycle).
  - `en` and `ack` are ignored.
- RUN:
  - `en` = 1 and `count` > 1: `count` ← `count` − 1, stay in RUN.
  - `en` = 1 and `count` = 1: `count` ← 0, go to DONE on the same edge.
  - `en` = 0: `count` holds.
  - `start` is ignored, so a re-load mid-run is impossible.
  - `count` never wraps below 0.
- DONE:
  - `count` holds at 0.
  - `ack` = 1: go to IDLE. `count` stays 0.
  - `start` asserted together with `ack`, or before it, is ignored. A new start is only possible from IDLE, i.e. one cycle after `ack`.
- Arithmetic: unsigned, WIDTH bits. The maximum load is 2^WIDTH − 1.

## Timing
- All outputs are registered except `bo`, which is decoded combinationally from the `count` register.
- Latency with `en` held high:
  - Load N at edge k.
  - `count` reads N−1 after edge k+1, and 0 after edge k+N.
  - `done` = 1 from edge k+N onward.
  - Total: N enabled cycles from load to `done`.
- Gaps in `en` stretch the latency by one cycle per low cycle.
- `done` is a level, not a pulse. It holds until `ack` is sampled high; it drops on the edge that samples `ack`.
- `busy` and `done` are never high at the same time.
- `rst` or `clean` mid-RUN or mid-DONE aborts immediately. No `done` is produced for the aborted run.

## Structure
- Shared package `counter_pkg` holds:
  - the state typedef `cd_state_t` {IDLE, RUN, DONE};
  - the default-width constant `CNT_W_DEFAULT` = 3.
- One sub-module is natural: `down_counter_core`.
  - Contains the WIDTH-bit register with synchronous clear, load and decrement controls, plus the `bo` zero-detect.
  - The top level contains only the FSM and the control decode.

## Test plan
- Reset: assert `rst` for 2 cycles -> `count` = 0, `busy` = 0, `done` = 0, `bo` = 1; `start` during `rst` is ignored.
- Basic run: `start` with `load_val` = 5, `en` held high -> `count` reads 5, 4, 3, 2, 1, 0; `done` = 1 exactly 5 cycles after the load edge; hold `ack` low 3 cycles -> `done` stays 1; then `ack` = 1 -> IDLE, `done` = 0.
- Zero and maximum loads: `load_val` = 0 -> DONE one edge after `start` with `busy` never high; `load_val` = 7 (WIDTH = 3) -> 7 enabled cycles to `done`, no wrap.
- Gapped enable: `load_val` = 3, `en` pattern 1, 0, 0, 1, 1 -> `count` 3, 2, 2, 2, 1, 0; `done` appears after the 5th cycle.
- Ignored inputs: `start` with `load_val` = 6 mid-RUN -> no reload; `start` + `ack` together in DONE -> IDLE with `count` = 0; `start` on the next cycle loads.
- Abort: `clean` at `count` = 2 in RUN -> IDLE, `count` = 0, `done` never asserted; repeat with `rst` during DONE -> `done` = 0 on the next edge.
